// File: rtl/riscv_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_irq_ctrl_pkg
//  Brief    : Shared register offsets, ID width and cfg FSM state encoding
//             for the platform interrupt controller.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef RISCV_IRQC_DEFS
`define RISCV_IRQC_DEFS
`define IRQC_PENDING   8'h00
`define IRQC_ENABLE    8'h04
`define IRQC_THRESH    8'h08
`define IRQC_CLAIM     8'h0C
`define IRQC_EDGE      8'h10
`define IRQC_PRIO_BASE 8'h40
`endif

package riscv_irq_ctrl_pkg;

    // Interrupt IDs are 1..31, 0 means "no interrupt"
    localparam int         c_ID_W         = 5;

    localparam logic [7:0] c_ADDR_PENDING = `IRQC_PENDING;
    localparam logic [7:0] c_ADDR_ENABLE  = `IRQC_ENABLE;
    localparam logic [7:0] c_ADDR_THRESH  = `IRQC_THRESH;
    localparam logic [7:0] c_ADDR_CLAIM   = `IRQC_CLAIM;
    localparam logic [7:0] c_ADDR_EDGE    = `IRQC_EDGE;
    localparam logic [7:0] c_ADDR_PRIO    = `IRQC_PRIO_BASE;

    // Cfg port state: ACK is the single cycle in which cfg_ack is high
    typedef enum logic [0:0] {
        CFG_IDLE = 1'b0,
        CFG_ACK  = 1'b1
    } cfg_state_e;

    // Zero-extend an interrupt ID onto the 32-bit read bus
    function automatic logic [31:0] zext_id(input logic [c_ID_W-1:0] id);
        return {{(32-c_ID_W){1'b0}}, id};
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_irq_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_irq_gateway
//  Brief    : Per-source interrupt gateway: synchroniser, edge detect,
//             pending flop and in-service flop.
//  Revision : 1.0  initial release
// ============================================================================

module riscv_irq_gateway #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,          // active-high asynchronous reset
    input  logic i_irq_raw,
    input  logic i_edge_mode,
    input  logic i_claim_clr,
    input  logic i_complete_clr,
    output logic o_pending
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_line_d;
    logic                   r_pending;
    logic                   r_in_service;
    logic                   w_line;
    logic                   w_set;

    assign w_line = r_sync[SYNC_STAGES-1];

    // New requests are only accepted while the source is not in service,
    // so an edge arriving during service (or on the completing edge) is lost.
    assign w_set  = !r_in_service && (i_edge_mode ? (w_line && !r_line_d) : w_line);

    assign o_pending = r_pending;

    // Synchronise the raw line and keep its previous value for edge detect
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sync   <= '0;
            r_line_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_irq_raw};
            r_line_d <= w_line;
        end
    end

    // Pending / in-service tracking; a claim beats a same-edge gateway set
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pending    <= 1'b0;
            r_in_service <= 1'b0;
        end else if (i_claim_clr) begin
            r_pending    <= 1'b0;
            r_in_service <= 1'b1;
        end else begin
            if (w_set) begin
                r_pending <= 1'b1;
            end
            if (i_complete_clr) begin
                r_in_service <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/riscv_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_irq_ctrl
//  Brief    : Platform interrupt controller. Gateways per source, config
//             registers, priority arbiter, claim/complete over a simple
//             one-cycle-latency cfg port, registered ext_intr to the core.
//  Revision : 1.0  initial release
// ============================================================================

module riscv_irq_ctrl
    import riscv_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,      // active-high asynchronous reset
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_req,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic               cfg_ack,
    output logic [31:0]        cfg_rdata,
    output logic               ext_intr
);

    cfg_state_e          r_state;
    cfg_state_e          w_state_nxt;
    logic                w_accept;
    logic                w_rd;
    logic                w_wr;

    logic [NUM_SRC-1:0]  w_pending;
    logic [NUM_SRC-1:0]  w_claim_clr;
    logic [NUM_SRC-1:0]  w_complete_clr;
    logic [NUM_SRC-1:0]  r_enable;
    logic [NUM_SRC-1:0]  r_edge_sel;
    logic [PRIO_W-1:0]   r_thresh;
    logic [PRIO_W-1:0]   r_prio [NUM_SRC];

    logic [c_ID_W-1:0]   r_best_id;
    logic [c_ID_W-1:0]   w_arb_id;
    logic [PRIO_W-1:0]   w_arb_prio;
    logic                r_ext_intr;

    logic [5:0]          w_prio_idx;
    logic                w_prio_rng;
    logic                w_claim;
    logic                w_cmp;
    logic [31:0]         w_rd_mux;
    logic [31:0]         r_rdata;

    assign cfg_ack   = (r_state == CFG_ACK);
    assign cfg_rdata = r_rdata;
    assign ext_intr  = r_ext_intr;

    assign w_rd = w_accept && !cfg_we;
    assign w_wr = w_accept &&  cfg_we;

    // Priority window starts at 0x40; the per-source index is matched below
    assign w_prio_idx = cfg_addr[7:2] - 6'd16;
    assign w_prio_rng = (cfg_addr[7:6] != 2'b00) && (cfg_addr[1:0] == 2'b00);

    // A claim only has an effect when there is a winner to hand out
    assign w_claim = w_rd && (cfg_addr == c_ADDR_CLAIM) && (r_best_id != '0);
    assign w_cmp   = w_wr && (cfg_addr == c_ADDR_CLAIM);

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_gateway
            // Completion IDs outside 1..NUM_SRC simply match no source
            assign w_claim_clr[g]    = w_claim && (r_best_id == c_ID_W'(g + 1));
            assign w_complete_clr[g] = w_cmp && (cfg_wdata == 32'(g + 1));

            riscv_irq_gateway #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_gateway (
                .clk            (clk),
                .rst_n          (rst_n),
                .i_irq_raw      (irq_src[g]),
                .i_edge_mode    (r_edge_sel[g]),
                .i_claim_clr    (w_claim_clr[g]),
                .i_complete_clr (w_complete_clr[g]),
                .o_pending      (w_pending[g])
            );
        end
    endgenerate

    // Cfg port: accept when idle, acknowledge for exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            CFG_IDLE: begin
                if (cfg_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CFG_ACK;
                end
            end
            CFG_ACK: begin
                w_state_nxt = CFG_IDLE;
            end
            default: begin
                w_state_nxt = CFG_IDLE;
            end
        endcase
    end

    // Cfg port state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read data mux; unmapped addresses and bits above NUM_SRC read as 0
    always_comb begin
        w_rd_mux = '0;
        case (cfg_addr)
            c_ADDR_PENDING: w_rd_mux = 32'(w_pending);
            c_ADDR_ENABLE:  w_rd_mux = 32'(r_enable);
            c_ADDR_THRESH:  w_rd_mux = 32'(r_thresh);
            c_ADDR_CLAIM:   w_rd_mux = zext_id(r_best_id);
            c_ADDR_EDGE:    w_rd_mux = 32'(r_edge_sel);
            default:        w_rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_prio_rng && (w_prio_idx == 6'(i))) begin
                w_rd_mux = 32'(r_prio[i]);
            end
        end
    end

    // Read data is captured on acceptance and shown only during the ack cycle
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= '0;
        end
    end

    // Configuration register writes; read-only and unmapped writes fall through
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_enable   <= '0;
            r_edge_sel <= '0;
            r_thresh   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_prio[i] <= '0;
            end
        end else if (w_wr) begin
            case (cfg_addr)
                c_ADDR_ENABLE: r_enable   <= cfg_wdata[NUM_SRC-1:0];
                c_ADDR_THRESH: r_thresh   <= cfg_wdata[PRIO_W-1:0];
                c_ADDR_EDGE:   r_edge_sel <= cfg_wdata[NUM_SRC-1:0];
                default:       ;
            endcase
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_prio_rng && (w_prio_idx == 6'(i))) begin
                    r_prio[i] <= cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Arbiter: strictly-greater replacement keeps the lowest ID on ties,
    // and prio > threshold excludes priority 0 automatically.
    always_comb begin
        w_arb_id   = '0;
        w_arb_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_pending[i] && r_enable[i] && (r_prio[i] > r_thresh) &&
                (r_prio[i] > w_arb_prio)) begin
                w_arb_id   = c_ID_W'(i + 1);
                w_arb_prio = r_prio[i];
            end
        end
    end

    // Registered winner and interrupt line; a claim retires the winner at once
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_best_id  <= '0;
            r_ext_intr <= 1'b0;
        end else begin
            r_best_id  <= w_claim ? '0 : w_arb_id;
            r_ext_intr <= (r_best_id != '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_irq_ctrl
//  Brief    : Directed self-checking bench for riscv_irq_ctrl
//             (NUM_SRC=8, PRIO_W=3, SYNC_STAGES=2).
//  Revision : 1.0  initial release
// ============================================================================

module tb_riscv_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_src;
    logic        cfg_req;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;
    logic        ext_intr;

    int total = 0;
    int bad   = 0;

    riscv_irq_ctrl #(
        .NUM_SRC     (8),
        .PRIO_W      (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .cfg_req   (cfg_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ack   (cfg_ack),
        .cfg_rdata (cfg_rdata),
        .ext_intr  (ext_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    // One cfg access; ack must appear on the first negedge after acceptance
    task automatic cfg_acc(input logic we, input logic [7:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        rd  = '0;
        @(negedge clk);
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_wdata = wd;
        while (!got && n < 4) begin
            @(negedge clk);
            n++;
            if (cfg_ack === 1'b1) begin
                got = 1'b1;
                rd  = cfg_rdata;
            end
        end
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        total++;
        if (!got || n != 1) begin
            bad++;
            $display("FAIL cfg_ack_latency addr=%h: ack after %0d cycles (got=%0d), required 1", addr, n, got);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        cfg_acc(1'b1, addr, wd, dummy);
    endtask

    task automatic rd(input logic [7:0] addr, output logic [31:0] data);
        cfg_acc(1'b0, addr, 32'h0, data);
    endtask

    task automatic pulse0();
        irq_src[0] = 1'b1;
        repeat (3) @(negedge clk);
        irq_src[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [7:0]  addrs [8];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40, 8'h5C, 8'h20};
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ext_intr, cfg_ack, cfg_rdata} !== 34'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ext=%b ack=%b rdata=%h, required all 0", ext_intr, cfg_ack, cfg_rdata);
        end
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rd(addrs[i], r);
            total++;
            if (r !== 32'h0) begin
                bad++;
                $display("FAIL reset_reg addr=%h: got %h, required 0", addrs[i], r);
            end
        end
        wr(8'h04, 32'hFFFF_FFFF);
        rd(8'h04, r);
        total++;
        if (r !== 32'h0000_00FF) begin
            bad++;
            $display("FAIL enable_width: got %h, required 000000ff", r);
        end
        wr(8'h04, 32'h0);
        wr(8'h60, 32'h7);
        rd(8'h60, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL unmapped_prio8: got %h, required 0", r);
        end
        wr(8'h00, 32'hFF);
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL pending_readonly: got %h, required 0", r);
        end
    endtask

    task automatic test_back_to_back();
        int  acks;
        logic prev;
        wr(8'h08, 32'h5);
        acks = 0;
        prev = 1'b0;
        @(negedge clk);
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 8'h08;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (cfg_ack === 1'b1 && prev) begin
                bad++;
                $display("FAIL ack_back_to_back cycle %0d: ack high twice in a row, required single pulse", i);
            end
            total++;
            if (cfg_ack === 1'b1 && cfg_rdata !== 32'h5) begin
                bad++;
                $display("FAIL b2b_rdata cycle %0d: got %h, required 5", i, cfg_rdata);
            end else if (cfg_ack !== 1'b1 && cfg_rdata !== 32'h0) begin
                bad++;
                $display("FAIL rdata_idle cycle %0d: got %h, required 0", i, cfg_rdata);
            end
            if (cfg_ack === 1'b1) acks++;
            prev = (cfg_ack === 1'b1);
        end
        cfg_req = 1'b0;
        total++;
        if (acks != 3) begin
            bad++;
            $display("FAIL b2b_ack_count: got %0d, required 3", acks);
        end
        wr(8'h08, 32'h0);
    endtask

    task automatic test_level();
        logic [31:0] r;
        wr(8'h40, 32'd3);
        wr(8'h08, 32'd1);
        wr(8'h04, 32'h01);
        @(negedge clk);
        irq_src[0] = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (ext_intr !== 1'b0) begin
            bad++;
            $display("FAIL level_latency_early: ext_intr=%b, required 0", ext_intr);
        end
        @(negedge clk);
        total++;
        if (ext_intr !== 1'b1) begin
            bad++;
            $display("FAIL level_latency: ext_intr=%b, required 1", ext_intr);
        end
        rd(8'h0C, r);
        total++;
        if (r !== 32'd1) begin
            bad++;
            $display("FAIL level_claim: got %h, required 1", r);
        end
        @(negedge clk);
        total++;
        if (ext_intr !== 1'b0) begin
            bad++;
            $display("FAIL level_ext_drop: ext_intr=%b, required 0", ext_intr);
        end
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL level_in_service_pending: got %h, required 0", r);
        end
        wr(8'h0C, 32'd1);
        rd(8'h00, r);
        total++;
        if (r !== 32'h1) begin
            bad++;
            $display("FAIL level_repend: got %h, required 1", r);
        end
        irq_src[0] = 1'b0;
        repeat (5) @(negedge clk);
        rd(8'h0C, r);
        total++;
        if (r !== 32'd1) begin
            bad++;
            $display("FAIL level_reclaim: got %h, required 1", r);
        end
        wr(8'h0C, 32'd1);
        repeat (3) @(negedge clk);
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL level_clean: got %h, required 0", r);
        end
    endtask

    task automatic test_priority();
        logic [31:0] r;
        logic [31:0] exp_ids [3];
        exp_ids = '{32'd2, 32'd3, 32'd6};
        wr(8'h48, 32'd5);
        wr(8'h54, 32'd5);
        wr(8'h44, 32'd7);
        wr(8'h04, 32'h26);
        @(negedge clk);
        irq_src = 8'h26;
        repeat (6) @(negedge clk);
        irq_src = 8'h00;
        repeat (4) @(negedge clk);
        rd(8'h00, r);
        total++;
        if (r !== 32'h26) begin
            bad++;
            $display("FAIL prio_pending: got %h, required 26", r);
        end
        for (int k = 0; k < 3; k++) begin
            rd(8'h0C, r);
            total++;
            if (r !== exp_ids[k]) begin
                bad++;
                $display("FAIL prio_claim%0d: got %h, required %h", k, r, exp_ids[k]);
            end
            wr(8'h0C, exp_ids[k]);
        end
        repeat (3) @(negedge clk);
        total++;
        if (ext_intr !== 1'b0) begin
            bad++;
            $display("FAIL prio_ext_idle: ext_intr=%b, required 0", ext_intr);
        end
    endtask

    task automatic test_threshold();
        logic [31:0] r;
        wr(8'h40, 32'd2);
        wr(8'h08, 32'd2);
        wr(8'h04, 32'h01);
        @(negedge clk);
        irq_src[0] = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (ext_intr !== 1'b0) begin
            bad++;
            $display("FAIL thresh_block: ext_intr=%b, required 0", ext_intr);
        end
        rd(8'h00, r);
        total++;
        if (r !== 32'h1) begin
            bad++;
            $display("FAIL thresh_pending: got %h, required 1", r);
        end
        wr(8'h08, 32'd1);
        repeat (2) @(negedge clk);
        total++;
        if (ext_intr !== 1'b1) begin
            bad++;
            $display("FAIL thresh_lowered: ext_intr=%b, required 1", ext_intr);
        end
        irq_src[0] = 1'b0;
        repeat (4) @(negedge clk);
        rd(8'h0C, r);
        total++;
        if (r !== 32'd1) begin
            bad++;
            $display("FAIL thresh_claim: got %h, required 1", r);
        end
        wr(8'h0C, 32'd1);
    endtask

    task automatic test_edge();
        logic [31:0] r;
        wr(8'h10, 32'h01);
        pulse0();
        rd(8'h0C, r);
        total++;
        if (r !== 32'd1) begin
            bad++;
            $display("FAIL edge_claim: got %h, required 1", r);
        end
        pulse0();
        pulse0();
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL edge_dropped: got %h, required 0", r);
        end
        wr(8'h0C, 32'd1);
        repeat (4) @(negedge clk);
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL edge_after_complete: got %h, required 0", r);
        end
        // A held-high line must not re-pend after complete in edge mode
        irq_src[0] = 1'b1;
        repeat (5) @(negedge clk);
        rd(8'h0C, r);
        total++;
        if (r !== 32'd1) begin
            bad++;
            $display("FAIL edge_hold_claim: got %h, required 1", r);
        end
        wr(8'h0C, 32'd1);
        repeat (4) @(negedge clk);
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL edge_no_repend: got %h, required 0", r);
        end
        irq_src[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_claim_race();
        logic [31:0] r;
        rd(8'h0C, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL empty_claim: got %h, required 0", r);
        end
        pulse0();
        rd(8'h0C, r);
        total++;
        if (r !== 32'd1) begin
            bad++;
            $display("FAIL race_claim: got %h, required 1", r);
        end
        wr(8'h0C, 32'd9);
        wr(8'h0C, 32'd0);
        pulse0();
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL bad_complete_ignored: got %h, required 0", r);
        end
        wr(8'h0C, 32'd1);
        pulse0();
        rd(8'h00, r);
        total++;
        if (r !== 32'h1) begin
            bad++;
            $display("FAIL good_complete: got %h, required 1", r);
        end
        rd(8'h0C, r);
        wr(8'h0C, 32'd1);
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] r;
        pulse0();
        repeat (2) @(negedge clk);
        @(negedge clk);
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 8'h00;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({ext_intr, cfg_ack, cfg_rdata} !== 34'h0) begin
                bad++;
                $display("FAIL reset_mid_outputs cycle %0d: ext=%b ack=%b rdata=%h, required all 0", i, ext_intr, cfg_ack, cfg_rdata);
            end
        end
        rst_n   = 1'b0;
        cfg_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (cfg_ack !== 1'b0) begin
                bad++;
                $display("FAIL late_ack cycle %0d: ack=%b, required 0", i, cfg_ack);
            end
        end
        rd(8'h00, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_pending: got %h, required 0", r);
        end
        rd(8'h10, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_edge: got %h, required 0", r);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        irq_src   = 8'h00;
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 8'h00;
        cfg_wdata = 32'h0;
        test_reset();
        test_back_to_back();
        test_level();
        test_priority();
        test_threshold();
        test_edge();
        test_claim_race();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
